// File: rtl/debug_unit.sv
`default_nettype none
// ============================================================================
// Module   : debug_unit
// Purpose  : Host-side debug controller for the 5-stage MIPS pipeline.
//            Decodes host UART command bytes into instruction-memory
//            writes and halt control, and streams a 44-byte snapshot of the
//            four pipeline latches back to the host after a RUN or STEP.
// Ports    : i_clk / i_reset (sync, active-low)      clock and reset
//            i_rx_data, i_rx_valid                    received host byte
//            o_tx_data, o_tx_valid, i_tx_ready        byte to host, handshake
//            i_IF_ID/ID_EX/EX_MEM/MEM_WB_latch        pipeline latch snapshots
//            i_program_end                            pipeline end-of-program
//            o_halt                                   1 = pipeline frozen
//            o_write_instruction_flag, o_instruction_to_write,
//            o_address_to_write_inst                  imem write port
// Options  : DEBUG_ACK_EN - when defined, a completed load answers 0xAA and
//            an unknown command byte answers 0x15; otherwise both are silent.
// Revision : 1.0 - initial release
// ============================================================================
module debug_unit #(
  parameter int unsigned IMEM_DEPTH_WORDS = 256,
  parameter logic [31:0] HALT_INSTR       = 32'hFFFF_FFFF,
  parameter int unsigned RUN_TIMEOUT      = 0
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic [7:0]   i_rx_data,
  input  logic         i_rx_valid,
  output logic [7:0]   o_tx_data,
  output logic         o_tx_valid,
  input  logic         i_tx_ready,
  input  logic [63:0]  i_IF_ID_latch,
  input  logic [138:0] i_ID_EX_latch,
  input  logic [75:0]  i_EX_MEM_latch,
  input  logic [70:0]  i_MEM_WB_latch,
  input  logic         i_program_end,
  output logic         o_halt,
  output logic         o_write_instruction_flag,
  output logic [31:0]  o_instruction_to_write,
  output logic [31:0]  o_address_to_write_inst
);

  localparam logic [31:0] ADDR_LAST  = 32'(4 * IMEM_DEPTH_WORDS - 4);
  localparam logic [31:0] TIMEOUT    = 32'(RUN_TIMEOUT);
  localparam logic [5:0]  LAST_BYTE  = 6'd43;
  localparam logic [7:0]  CMD_LOAD   = 8'h4C;
  localparam logic [7:0]  CMD_RUN    = 8'h52;
  localparam logic [7:0]  CMD_STEP   = 8'h53;
`ifdef DEBUG_ACK_EN
  localparam logic [7:0]  ACK_BYTE   = 8'hAA;
  localparam logic [7:0]  NAK_BYTE   = 8'h15;
`endif

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_LOAD_WR = 3'd2,
    ST_RUN     = 3'd3,
    ST_STEP    = 3'd4,
    ST_SNAP    = 3'd5,
`ifdef DEBUG_ACK_EN
    ST_SEND    = 3'd6,
    ST_ACK     = 3'd7
`else
    ST_SEND    = 3'd6
`endif
  } state_e;

  state_e         state_q, state_d;
  logic           halt_q,  halt_d;
  logic [31:0]    addr_q,  addr_d;
  logic [31:0]    word_q,  word_d;
  logic [5:0]     bcnt_q,  bcnt_d;   // byte index within a load word or a dump
  logic [31:0]    cnt_q,   cnt_d;    // unhalted cycles elapsed in RUN
  logic [351:0]   shift_q, shift_d;  // outgoing bytes, LSB byte is on the wire

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      halt_q  <= 1'b1;
      addr_q  <= '0;
      word_q  <= '0;
      bcnt_q  <= '0;
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      halt_q  <= halt_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      bcnt_q  <= bcnt_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d = state_q;
    halt_d  = halt_q;
    addr_d  = addr_q;
    word_d  = word_q;
    bcnt_d  = bcnt_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;

    case (state_q)
      ST_IDLE: begin
        halt_d = 1'b1;
        if (i_rx_valid) begin
          case (i_rx_data)
            CMD_LOAD: begin
              state_d = ST_LOAD;
              addr_d  = '0;
              bcnt_d  = '0;
            end
            CMD_RUN: begin
              state_d = ST_RUN;
              cnt_d   = '0;
            end
            CMD_STEP: begin
              state_d = ST_STEP;
            end
            default: begin
`ifdef DEBUG_ACK_EN
              shift_d = {344'd0, NAK_BYTE};
              state_d = ST_ACK;
`endif
            end
          endcase
        end
      end

      ST_LOAD: begin
        if (i_rx_valid) begin
          // Shift in from the top so the first byte ends up in [7:0].
          word_d = {i_rx_data, word_q[31:8]};
          if (bcnt_q == 6'd3) begin
            bcnt_d  = '0;
            state_d = ST_LOAD_WR;
          end else begin
            bcnt_d  = bcnt_q + 6'd1;
          end
        end
      end

      ST_LOAD_WR: begin
        addr_d = (addr_q == ADDR_LAST) ? 32'd0 : addr_q + 32'd4;
        if (word_q == HALT_INSTR) begin
`ifdef DEBUG_ACK_EN
          shift_d = {344'd0, ACK_BYTE};
          state_d = ST_ACK;
`else
          state_d = ST_IDLE;
`endif
        end else begin
          state_d = ST_LOAD;
        end
      end

      ST_RUN: begin
        // First RUN cycle is still halted; release it and guarantee at least
        // one unhalted cycle before any stop condition is honoured.
        if (halt_q) begin
          halt_d = 1'b0;
          cnt_d  = 32'd1;
        end else if (i_program_end || ((TIMEOUT != 32'd0) && (cnt_q >= TIMEOUT))) begin
          halt_d  = 1'b1;
          state_d = ST_SNAP;
        end else begin
          cnt_d  = cnt_q + 32'd1;
        end
      end

      ST_STEP: begin
        if (halt_q) begin
          halt_d = 1'b0;
        end else begin
          halt_d  = 1'b1;
          state_d = ST_SNAP;
        end
      end

      ST_SNAP: begin
        // Pipeline has been frozen for a full cycle, so the latches are settled.
        shift_d = {2'b00, i_MEM_WB_latch, i_EX_MEM_latch, i_ID_EX_latch, i_IF_ID_latch};
        bcnt_d  = '0;
        state_d = ST_SEND;
      end

      ST_SEND: begin
        if (i_tx_ready) begin
          shift_d = {8'h00, shift_q[351:8]};
          if (bcnt_q == LAST_BYTE) begin
            bcnt_d  = '0;
            state_d = ST_IDLE;
          end else begin
            bcnt_d  = bcnt_q + 6'd1;
          end
        end
      end

`ifdef DEBUG_ACK_EN
      ST_ACK: begin
        if (i_tx_ready) begin
          shift_d = '0;
          state_d = ST_IDLE;
        end
      end
`endif

      default: begin
        state_d = ST_IDLE;
        halt_d  = 1'b1;
      end
    endcase
  end

  always_comb begin
`ifdef DEBUG_ACK_EN
    o_tx_valid = (state_q == ST_SEND) || (state_q == ST_ACK);
`else
    o_tx_valid = (state_q == ST_SEND);
`endif
    o_tx_data                = o_tx_valid ? shift_q[7:0] : 8'h00;
    o_halt                   = halt_q;
    o_write_instruction_flag = (state_q == ST_LOAD_WR);
    o_instruction_to_write   = o_write_instruction_flag ? word_q : 32'd0;
    o_address_to_write_inst  = o_write_instruction_flag ? addr_q : 32'd0;
  end

endmodule
`default_nettype wire
